stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//   Inverse of the 2:1 word selector: steers one 4-bit word stream to one of two
//   downstream ports. Uses valid/ready handshakes, one registered holding slot per
//   port, and packet-locked routing. Sits between a single producer (UART RX,
//   keypad scanner) and two consumers (display driver, LED bank).
// PARAMETERS
//   DATA_W  4  width of each data word
//   CNT_W   8  width of per-port word counters (only with STREAM_DEMUX_STATS_EN)
// PORTS
//   clk        in   1       sole clock; all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   in_data    in   DATA_W  input word
//   in_sel     in   1       route select: 0 -> port A, 1 -> port B; sampled on first word of packet
//   in_last    in   1       marks final word of packet
//   in_valid   in   1       in_data/in_sel/in_last valid
//   in_ready   out  1       word accepted when in_valid && in_ready
//   a_data     out  DATA_W  port A word (registered)
//   a_valid    out  1       port A slot full
//   a_ready    in   1       port A consumer accepts
//   b_data     out  DATA_W  port B word (registered)
//   b_valid    out  1       port B slot full
//   b_ready    in   1       port B consumer accepts
//   busy       out  1       1 while a packet is locked (state != IDLE)
//   a_count    out  CNT_W   words delivered on A (only with STREAM_DEMUX_STATS_EN)
//   b_count    out  CNT_W   words delivered on B (only with STREAM_DEMUX_STATS_EN)
// BEHAVIOUR
//   - Reset: state IDLE; a_valid/b_valid 0; a_data/b_data 0; busy 0; counts 0.
//     Reset mid-packet drops held words and the lock. in_ready is combinational.
//   - FSM: IDLE, LOCK_A, LOCK_B.
//     IDLE + accept with in_last=0 -> LOCK_A/LOCK_B per in_sel.
//     IDLE + accept with in_last=1 -> stays IDLE (single-word packet).
//     LOCK_x + accept with in_last=1 -> IDLE. in_sel is ignored while LOCK_x.
//   - Target port: IDLE -> in_sel; LOCK_A -> A; LOCK_B -> B.
//   - in_ready = !tgt_valid || tgt_ready. The non-target port's state never
//     gates in_ready.
//   - Accepted word loads the target slot; x_valid rises next cycle. Latency is
//     1 clk. Throughput is 1 word/clk when the consumer holds ready high.
//   - Same-cycle drain and load of one slot: slot reloads and x_valid stays 1.
//     No bubble.
//   - Slot drains when x_valid && x_ready; x_valid clears unless reloaded.
//     x_data holds its last value after draining (not cleared).
//   - Non-target slot still drains normally during the other port's packet.
//   - in_valid=0: no state change. in_sel/in_last are don't-care.
// CONFIGURATION
//   STREAM_DEMUX_STATS_EN defined:
//     a_count/b_count ports exist.
//     Each increments by 1 on its port's x_valid && x_ready.
//     Counts saturate at 2**CNT_W-1 and do not wrap.
//     rst clears both counts.
//   STREAM_DEMUX_STATS_EN undefined:
//     Count ports and counter logic are absent.
//     All other behaviour is identical.
// STRUCTURE
//   - Package stream_demux_pkg holds:
//     the state typedef (IDLE/LOCK_A/LOCK_B, 2-bit encoding);
//     DATA_W_DEF=4 and CNT_W_DEF=8.
//   - Sub-module stream_slot is a one-entry registered valid/ready slot with a
//     load strobe. It is instantiated twice (A, B).
//   - The top level holds the FSM, in_ready steering and the optional counters.
// TESTING
//   1. rst=1 for 2 clk -> a_valid=b_valid=0, busy=0, in_ready=1; counts 0 with
//      STREAM_DEMUX_STATS_EN.
//   2. Single word 4'h5, sel=1, last=1, b_ready=1 -> b_valid=1 with b_data=5 on
//      next clk; busy stays 0; a_valid stays 0.
//   3. Packet 4'h1,2,3 on sel=0; sel toggles to 1 on words 2-3 -> all three
//      appear on A, in order, one per clk; busy=1 until word 3 accepted.
//   4. Packet to A with a_ready=0 -> after 1 word in_ready=0 and stays 0 until
//      a_ready=1. Next word loads in the same clk as the drain; a_valid does not
//      drop.
//   5. b_valid=1 held (b_ready=0) while a packet goes to A -> A traffic flows
//      unimpeded; in_ready tracks only A.
//   6. Mid-packet rst after 2 of 4 words to B -> b_valid=0 and state IDLE the
//      next clk. A new packet with sel=0 routes to A. With STREAM_DEMUX_STATS_EN
//      and CNT_W=2, 5 drains saturate a_count at 3.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream_demux block.
//   state_t     : packet-lock FSM encoding (IDLE / LOCK_A / LOCK_B)
//   DATA_W_DEF  : default word width
//   CNT_W_DEF   : default per-port delivered-word counter width
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/stream_slot.sv
// One-entry registered valid/ready holding slot with a load strobe.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : write load_data into the slot this cycle
//   load_data  : word to store
//   data       : held word (keeps its value after draining)
//   valid      : slot full
//   ready      : downstream accepts; slot drains on valid && ready
// A load in the same cycle as a drain refills the slot with no bubble.
module stream_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  // ---- stage p1: holding register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (load) begin
        vld_p1  <= 1'b1;
        data_p1 <= load_data;
      end else if (vld_p1 && ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign data  = data_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: steers a single valid/ready word stream to port A or port B.
// The route is chosen by in_sel on the first word of a packet and held until
// the word carrying in_last is accepted. Each port has one registered slot.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_data/in_sel/in_last      : input word, route select, end-of-packet
//   in_valid/in_ready           : input handshake (in_ready is combinational)
//   a_data/a_valid/a_ready      : port A output stream
//   b_data/b_valid/b_ready      : port B output stream
//   busy                        : a packet is locked to a port
//   a_count/b_count             : saturating delivered-word counts
//                                 (present only with STREAM_DEMUX_STATS_EN)
// Build option: define STREAM_DEMUX_STATS_EN to add the delivery counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX_STATS_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
`ifdef STREAM_DEMUX_STATS_EN
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count,
`endif
  output logic              busy
);

  state_t state, state_nxt;
  logic   tgt_b;
  logic   accept;
  logic   load_a, load_b;

  // Target port: follow in_sel only between packets; inside a packet the
  // lock decides, so a toggling in_sel mid-packet cannot split it.
  always_comb begin
    tgt_b = 1'b0;
    case (state)
      IDLE:    tgt_b = in_sel;
      LOCK_A:  tgt_b = 1'b0;
      LOCK_B:  tgt_b = 1'b1;
      default: tgt_b = 1'b0;
    endcase
  end

  // Only the target slot can back-pressure the producer.
  assign in_ready = tgt_b ? (!b_valid || b_ready) : (!a_valid || a_ready);
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && !tgt_b;
  assign load_b   = accept &&  tgt_b;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_last)         state_nxt = IDLE;
      else if (state == IDLE) state_nxt = in_sel ? LOCK_B : LOCK_A;
    end
  end

  stream_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (in_data),
    .data      (a_data),
    .valid     (a_valid),
    .ready     (a_ready)
  );

  stream_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (in_data),
    .data      (b_data),
    .valid     (b_valid),
    .ready     (b_ready)
  );

`ifdef STREAM_DEMUX_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + 1'b1;
  endfunction

  // ---- delivery counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_valid && a_ready) a_count <= sat_inc(a_count);
      if (b_valid && b_ready) b_count <= sat_inc(b_count);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed testbench for stream_demux. Inputs change on the falling edge;
// outputs are checked on the falling edge (or shortly after an input change
// for the combinational in_ready).
// Define STREAM_DEMUX_STATS_EN to build and check the counter variant (CNT_W=2).
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_sel, in_last, in_valid, in_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_valid, a_ready, b_valid, b_ready, busy;
`ifdef STREAM_DEMUX_STATS_EN
  logic [1:0]        a_count, b_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef STREAM_DEMUX_STATS_EN
  stream_demux #(.DATA_W(DATA_W), .CNT_W(2)) dut (
`else
  stream_demux #(.DATA_W(DATA_W)) dut (
`endif
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
`ifdef STREAM_DEMUX_STATS_EN
    .a_count  (a_count),
    .b_count  (b_count),
`endif
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] d, input logic s, input logic l, input logic v);
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = v;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    a_ready = 1'b0;
    b_ready = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a_data", a_data, 0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
`endif
    rst = 1'b0;

    // 2. single-word packet to B
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(4'h5, 1'b1, 1'b1, 1'b1);
    #1 chk("t2_in_ready", in_ready, 1);
    step();
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_b_valid", b_valid, 1);
    chk("t2_b_data", b_data, 4'h5);
    chk("t2_busy", busy, 0);
    chk("t2_a_valid", a_valid, 0);
    step();
    chk("t2_b_drained", b_valid, 0);
    chk("t2_b_data_hold", b_data, 4'h5);

    // 3. three-word packet locked to A despite in_sel toggling
    drive(4'h1, 1'b0, 1'b0, 1'b1);
    step();
    chk("t3_w1_a_data", a_data, 4'h1);
    chk("t3_w1_a_valid", a_valid, 1);
    chk("t3_w1_busy", busy, 1);
    drive(4'h2, 1'b1, 1'b0, 1'b1);
    step();
    chk("t3_w2_a_data", a_data, 4'h2);
    chk("t3_w2_b_valid", b_valid, 0);
    chk("t3_w2_busy", busy, 1);
    drive(4'h3, 1'b1, 1'b1, 1'b1);
    step();
    chk("t3_w3_a_data", a_data, 4'h3);
    chk("t3_w3_a_valid", a_valid, 1);
    chk("t3_w3_b_valid", b_valid, 0);
    chk("t3_w3_busy", busy, 0);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_drained", a_valid, 0);

    // 4. back-pressure on A, then drain+load in one cycle
    a_ready = 1'b0;
    drive(4'h7, 1'b0, 1'b0, 1'b1);
    #1 chk("t4_in_ready0", in_ready, 1);
    step();
    chk("t4_a_valid", a_valid, 1);
    drive(4'h8, 1'b1, 1'b1, 1'b1);
    #1 chk("t4_stall", in_ready, 0);
    step();
    chk("t4_stall_data", a_data, 4'h7);
    chk("t4_stall_ready", in_ready, 0);
    chk("t4_stall_busy", busy, 1);
    a_ready = 1'b1;
    #1 chk("t4_release", in_ready, 1);
    step();
    chk("t4_no_bubble", a_valid, 1);
    chk("t4_reload_data", a_data, 4'h8);
    chk("t4_busy", busy, 0);
    chk("t4_b_valid", b_valid, 0);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t4_drained", a_valid, 0);

    // 5. B held full while a packet flows to A
    b_ready = 1'b0;
    drive(4'h9, 1'b1, 1'b1, 1'b1);
    step();
    chk("t5_b_full", b_valid, 1);
    drive(4'h4, 1'b0, 1'b0, 1'b1);
    #1 chk("t5_rdy_w1", in_ready, 1);
    step();
    chk("t5_w1_a_data", a_data, 4'h4);
    chk("t5_w1_b_data", b_data, 4'h9);
    drive(4'h6, 1'b1, 1'b1, 1'b1);
    #1 chk("t5_rdy_w2", in_ready, 1);
    step();
    chk("t5_w2_a_data", a_data, 4'h6);
    chk("t5_w2_b_valid", b_valid, 1);
    chk("t5_w2_b_data", b_data, 4'h9);
    chk("t5_w2_busy", busy, 0);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    a_ready = 1'b0;
    #1 chk("t5_a_stall", in_ready, 0);
    a_ready = 1'b1;
    #1 chk("t5_a_free", in_ready, 1);
    in_sel = 1'b1;
    #1 chk("t5_b_tgt", in_ready, 0);
    in_sel  = 1'b0;
    b_ready = 1'b1;
    step();
    chk("t5_a_drained", a_valid, 0);
    chk("t5_b_drained", b_valid, 0);

    // 6. reset in the middle of a B packet, then reuse on A
    b_ready = 1'b0;
    drive(4'hC, 1'b1, 1'b0, 1'b1);
    step();
    b_ready = 1'b1;
    drive(4'hD, 1'b0, 1'b0, 1'b1);
    step();
    chk("t6_mid_b_data", b_data, 4'hD);
    chk("t6_mid_busy", busy, 1);
    b_ready = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_b_valid", b_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_b_data", b_data, 0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("t6_rst_a_count", a_count, 0);
`endif
    drive(4'hA, 1'b0, 1'b1, 1'b1);
    step();
    chk("t6_a_valid", a_valid, 1);
    chk("t6_a_data", a_data, 4'hA);
    chk("t6_b_valid", b_valid, 0);
    for (int i = 1; i < 5; i++) begin
      drive(4'hA + 4'(i), 1'b0, 1'b1, 1'b1);
      step();
    end
    chk("t6_last_a_data", a_data, 4'hE);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_end_a_valid", a_valid, 0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("t6_a_count_sat", a_count, 3);
    chk("t6_b_count", b_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
